// File: rtl/draw_player2_ai_ctl.sv
// Player-2 AI paddle: tick-rate-limited motion toward a state-dependent clamped target.
// State and position are registered; each changes one edge after its cause. No backpressure.
module draw_player2_ai_ctl #(
  parameter int RADIUS_BALL    = 10,
  parameter int PLAYERS_RADIUS = 20,
  parameter int MID_X          = 512,
  parameter int X_MIN          = 532,
  parameter int X_MAX          = 1004,
  parameter int Y_MIN          = 20,
  parameter int Y_MAX          = 748,
  parameter int HOME_X         = 900,
  parameter int HOME_Y         = 362,
  parameter int STEP           = 2,
  parameter int TICK_DIV       = 4,
  parameter int RECOVER_TICKS  = 64
) (
  input  logic        clk_in,
  input  logic        rst_n,
  input  logic        enable,
  input  logic [11:0] xpos_ball,
  input  logic [11:0] ypos_ball,
  output logic [11:0] xpos_player_2,
  output logic [11:0] ypos_player_2,
  output logic [1:0]  ai_state
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DEFEND  = 2'd1,
    ATTACK  = 2'd2,
    RECOVER = 2'd3
  } state_t;

  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int RW = (RECOVER_TICKS > 1) ? $clog2(RECOVER_TICKS) : 1;

  localparam logic [TW-1:0]     TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [RW-1:0]     REC_LAST  = RW'(RECOVER_TICKS - 1);
  localparam logic signed [12:0] XMIN_S   = 13'(X_MIN);
  localparam logic signed [12:0] XMAX_S   = 13'(X_MAX);
  localparam logic signed [12:0] YMIN_S   = 13'(Y_MIN);
  localparam logic signed [12:0] YMAX_S   = 13'(Y_MAX);
  localparam logic signed [12:0] HOMEX_S  = 13'(HOME_X);
  localparam logic signed [12:0] HOMEY_S  = 13'(HOME_Y);
  localparam logic signed [12:0] STEP_S   = 13'(STEP);
  localparam logic signed [12:0] REACH_S  = 13'(RADIUS_BALL + PLAYERS_RADIUS);

  function automatic logic signed [12:0] clamp(input logic signed [12:0] v,
                                               input logic signed [12:0] lo,
                                               input logic signed [12:0] hi);
    if (v < lo)      return lo;
    else if (v > hi) return hi;
    else             return v;
  endfunction

  // Move at most STEP toward tgt; inside STEP snap exactly onto it.
  function automatic logic [11:0] step_axis(input logic [11:0] pos,
                                            input logic signed [12:0] tgt);
    logic signed [12:0] p;
    logic signed [12:0] d;
    p = $signed({1'b0, pos});
    d = tgt - p;
    if (d >= STEP_S)       return 12'(p + STEP_S);
    else if (d <= -STEP_S) return 12'(p - STEP_S);
    else                   return 12'(tgt);
  endfunction

  state_t            state_q, state_d;
  logic [TW-1:0]     tick_cnt;
  logic [RW-1:0]     rec_cnt;
  logic              tick;
  logic              rec_load;
  logic signed [12:0] bx, by, dx, dy, adx, ady;
  logic signed [12:0] tx, ty;
  logic              contact, behind, puck_right;

  assign tick     = (tick_cnt == TICK_LAST);
  assign ai_state = state_q;

  assign bx  = $signed({1'b0, xpos_ball});
  assign by  = $signed({1'b0, ypos_ball});
  assign dx  = bx - $signed({1'b0, xpos_player_2});
  assign dy  = by - $signed({1'b0, ypos_player_2});
  assign adx = (dx < 0) ? -dx : dx;
  assign ady = (dy < 0) ? -dy : dy;

  assign contact    = (adx <= REACH_S) && (ady <= REACH_S);
  assign behind     = (xpos_ball > xpos_player_2);
  assign puck_right = (xpos_ball >= 12'(MID_X));

  always_comb begin
    tx = HOMEX_S;
    ty = HOMEY_S;
    case (state_q)
      DEFEND:  ty = by;
      ATTACK:  begin tx = bx; ty = by; end
      default: ;
    endcase
    tx = clamp(tx, XMIN_S, XMAX_S);
    ty = clamp(ty, YMIN_S, YMAX_S);
  end

  always_comb begin
    state_d  = state_q;
    rec_load = 1'b0;
    if (!enable) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    state_d = DEFEND;
        DEFEND:  if (puck_right) state_d = ATTACK;
        ATTACK: begin
          if (contact || behind) begin
            state_d  = RECOVER;
            rec_load = 1'b1;
          end else if (!puck_right) begin
            state_d = DEFEND;
          end
        end
        RECOVER: if (tick && rec_cnt == REC_LAST) state_d = DEFEND;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      tick_cnt      <= '0;
      rec_cnt       <= '0;
      xpos_player_2 <= 12'(HOME_X);
      ypos_player_2 <= 12'(HOME_Y);
    end else begin
      state_q  <= state_d;
      tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
      if (rec_load)
        rec_cnt <= '0;
      else if (state_q == RECOVER && tick)
        rec_cnt <= rec_cnt + 1'b1;
      // Target comes from the state in force during the tick cycle.
      if (tick) begin
        xpos_player_2 <= step_axis(xpos_player_2, tx);
        ypos_player_2 <= step_axis(ypos_player_2, ty);
      end
    end
  end

endmodule
